// File: rtl/netlist_graph_pkg.sv
// Shared types for the netlist fanout reader.
// Holds node/edge types and the reader FSM encoding.
package netlist_graph_pkg;

    localparam int NODE_W_DEFAULT = 8;

    typedef logic [NODE_W_DEFAULT-1:0] node_t;

    typedef struct packed {
        node_t src;
        node_t dst;
    } edge_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EMIT = 2'd2,
        S_TERM = 2'd3
    } state_e;

endpackage

// File: rtl/fanout_edge_table.sv
// Append-only edge storage with clear and one combinational read port.
// The count doubles as the write pointer.
module fanout_edge_table
    import netlist_graph_pkg::*;
#(
    parameter int NODE_W = NODE_W_DEFAULT,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              clr,
    input  logic [NODE_W-1:0] w_src,
    input  logic [NODE_W-1:0] w_dst,
    input  logic [AW-1:0]     r_idx,
    output logic [NODE_W-1:0] r_src,
    output logic [NODE_W-1:0] r_dst,
    output logic [CW-1:0]     count,
    output logic              full
);

    logic [NODE_W-1:0] src_mem [DEPTH];
    logic [NODE_W-1:0] dst_mem [DEPTH];

    assign full  = (count == CW'(DEPTH));
    assign r_src = src_mem[r_idx];
    assign r_dst = dst_mem[r_idx];

    always_ff @(posedge clk) begin
        if (we && !clr && !full) begin
            src_mem[count[AW-1:0]] <= w_src;
            dst_mem[count[AW-1:0]] <= w_dst;
        end
    end

    // Clear beats a coincident write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (we && !full) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/netlist_fanout_reader.sv
// Streams the fanout of a queried node from a loaded edge list,
// one beat per matching edge followed by a terminator beat.
module netlist_fanout_reader
    import netlist_graph_pkg::*;
#(
    parameter int NODE_W = NODE_W_DEFAULT,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [NODE_W-1:0] wr_src,
    input  logic [NODE_W-1:0] wr_dst,
    output logic              wr_ready,
    input  logic              clr,
    input  logic              q_valid,
    input  logic [NODE_W-1:0] q_node,
    output logic              q_ready,
    output logic              out_valid,
    output logic [NODE_W-1:0] out_node,
    output logic              out_hit,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CW-1:0]     edge_count,
    output logic              busy
);

    state_e            st;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     cnt_r;
    logic [NODE_W-1:0] key;
    logic [NODE_W-1:0] dst_r;
    logic [NODE_W-1:0] rd_src;
    logic [NODE_W-1:0] rd_dst;
    logic              full;
    logic              idle;
    logic              at_end;

    assign idle      = (st == S_IDLE);
    assign wr_ready  = idle && !full;
    assign q_ready   = idle;
    assign busy      = !idle;
    assign out_hit   = (st == S_EMIT);
    assign out_last  = (st == S_TERM);
    assign out_valid = out_hit || out_last;
    assign out_node  = out_hit ? dst_r : '0;
    assign at_end    = ((idx + 1'b1) == cnt_r);

    fanout_edge_table #(
        .NODE_W (NODE_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_valid && wr_ready),
        .clr   (clr && idle),
        .w_src (wr_src),
        .w_dst (wr_dst),
        .r_idx (idx[AW-1:0]),
        .r_src (rd_src),
        .r_dst (rd_dst),
        .count (edge_count),
        .full  (full)
    );

    // Reaching the captured count jumps straight to TERM so an
    // empty scan terminates the cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= S_IDLE;
            idx   <= '0;
            cnt_r <= '0;
            key   <= '0;
            dst_r <= '0;
        end else begin
            unique case (st)
                S_IDLE: begin
                    if (q_valid) begin
                        key   <= q_node;
                        idx   <= '0;
                        cnt_r <= edge_count;
                        st    <= (edge_count == '0) ? S_TERM : S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (rd_src == key) begin
                        dst_r <= rd_dst;
                        st    <= S_EMIT;
                    end else if (at_end) begin
                        st <= S_TERM;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (at_end) begin
                            st <= S_TERM;
                        end else begin
                            idx <= idx + 1'b1;
                            st  <= S_SCAN;
                        end
                    end
                end
                S_TERM: begin
                    if (out_ready) st <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_netlist_fanout_reader.sv
// Scoreboard bench for netlist_fanout_reader: directed loads and
// queries push expected beats, a monitor pops them on handshakes.
module tb_netlist_fanout_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_src = '0;
    logic [7:0] wr_dst = '0;
    logic       wr_ready;
    logic       clr = 1'b0;
    logic       q_valid = 1'b0;
    logic [7:0] q_node = '0;
    logic       q_ready;
    logic       out_valid;
    logic [7:0] out_node;
    logic       out_hit;
    logic       out_last;
    logic       out_ready = 1'b1;
    logic [4:0] edge_count;
    logic       busy;

    typedef struct packed {
        logic [7:0] node;
        logic       hit;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    netlist_fanout_reader dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_src     (wr_src),
        .wr_dst     (wr_dst),
        .wr_ready   (wr_ready),
        .clr        (clr),
        .q_valid    (q_valid),
        .q_node     (q_node),
        .q_ready    (q_ready),
        .out_valid  (out_valid),
        .out_node   (out_node),
        .out_hit    (out_hit),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .edge_count (edge_count),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected got node=%0d hit=%0d last=%0d want none",
                         out_node, out_hit, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_node, out_hit, out_last} !== e) begin
                    errors++;
                    $display("FAIL beat got node=%0d hit=%0d last=%0d want node=%0d hit=%0d last=%0d",
                             out_node, out_hit, out_last, e.node, e.hit, e.last);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic push(input int n, input bit h, input bit l);
        beat_t b;
        b.node = 8'(n);
        b.hit  = h;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int s, input int d);
        wr_valid = 1'b1;
        wr_src   = 8'(s);
        wr_dst   = 8'(d);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic query(input int n);
        q_valid = 1'b1;
        q_node  = 8'(n);
        step();
        q_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && q_ready) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk(name, int'(done), 1);
        exp_q.delete();
    endtask

    task automatic wait_valid(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk(name, int'(done), 1);
    endtask

    initial begin
        #2;
        chk("rst_count", int'(edge_count), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_q_ready", int'(q_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        step();
        rst = 1'b0;
        step();

        wr(1, 3); wr(2, 3); wr(1, 4); wr(3, 5);
        chk("load4_count", int'(edge_count), 4);

        push(3, 1, 0); push(4, 1, 0); push(0, 0, 1);
        query(1);
        chk("query_busy", int'(busy), 1);
        wait_idle("q1_done");

        push(0, 0, 1);
        query(9);
        wait_idle("q9_done");

        push(5, 1, 0); push(0, 0, 1);
        query(3);
        wait_idle("q3_done");

        out_ready = 1'b0;
        push(3, 1, 0); push(0, 0, 1);
        query(2);
        wait_idle_hold();
        out_ready = 1'b1;
        wait_idle("q2_done");

        out_ready = 1'b0;
        push(3, 1, 0); push(4, 1, 0); push(0, 0, 1);
        query(1);
        wait_valid("busy_wait");
        chk("busy_wr_ready", int'(wr_ready), 0);
        wr(1, 7);
        chk("busy_no_store", int'(edge_count), 4);
        out_ready = 1'b1;
        wait_idle("q1b_done");

        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_count", int'(edge_count), 0);

        push(0, 0, 1);
        query(7);
        chk("empty_term_valid", int'(out_valid), 1);
        chk("empty_term_last", int'(out_last), 1);
        chk("empty_count", int'(edge_count), 0);
        wait_idle("q7_done");

        for (int i = 0; i < 16; i++) wr(i, 100 + i);
        chk("full_count", int'(edge_count), 16);
        chk("full_wr_ready", int'(wr_ready), 0);
        wr(0, 200);
        chk("full_ignore", int'(edge_count), 16);
        push(100, 1, 0); push(0, 0, 1);
        query(0);
        wait_idle("q0_done");
        push(115, 1, 0); push(0, 0, 1);
        query(15);
        wait_idle("q15_done");
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("full_clr", int'(edge_count), 0);

        clr = 1'b1;
        wr(8, 9);
        clr = 1'b0;
        chk("clr_wins", int'(edge_count), 0);

        wr(5, 6);
        out_ready = 1'b0;
        push(6, 1, 0);
        query(5);
        wait_valid("emit_wait");
        chk("emit_node", int'(out_node), 6);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_hit", int'(out_hit), 0);
        chk("abort_node", int'(out_node), 0);
        chk("abort_busy", int'(busy), 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_q_ready", int'(q_ready), 1);
        chk("post_count", int'(edge_count), 0);
        chk("post_out_valid", int'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic wait_idle_hold();
        logic [7:0] held;
        wait_valid("hold_wait");
        held = out_node;
        chk("hold_first", int'(held), 3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_node", int'(out_node), 3);
            chk("hold_valid", int'(out_valid), 1);
        end
    endtask

endmodule

// File: doc/netlist_fanout_reader.md
NETLIST_FANOUT_READER -- requirements
Module: netlist_fanout_reader

Interface
REQ-001 The block SHALL have parameter NODE_W, default 8, giving the node identifier width.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the edge-table capacity (power of two, >= 2).
REQ-003 The block SHALL have these ports, one clock, reset asynchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- wr_valid  in  1  edge-load request
- wr_src  in  NODE_W  edge driver node
- wr_dst  in  NODE_W  edge load node
- wr_ready  out  1  edge accepted when high with wr_valid
- clr  in  1  empty the edge table
- q_valid  in  1  fanout query request
- q_node  in  NODE_W  node whose fanout is requested
- q_ready  out  1  query accepted when high with q_valid
- out_valid  out  1  result beat valid
- out_node  out  NODE_W  fanout destination node
- out_hit  out  1  1 = data beat, 0 = terminator beat
- out_last  out  1  final beat of the response
- out_ready  in  1  consumer accepts beat
- edge_count  out  $clog2(DEPTH)+1  edges stored
- busy  out  1  query in progress

Function
REQ-004 The block SHALL store an edge on the cycle wr_valid && wr_ready, at index edge_count, and increment edge_count.
REQ-005 wr_ready SHALL be high only in IDLE with edge_count < DEPTH; at edge_count == DEPTH writes SHALL be refused, with no overwrite.
REQ-006 clr in IDLE SHALL set edge_count to 0 next cycle; if clr and a write coincide, clr SHALL win and the write SHALL be discarded; clr SHALL be ignored while busy.
REQ-007 q_ready SHALL equal state == IDLE; a query is accepted on q_valid && q_ready.
REQ-008 The FSM SHALL have states IDLE, SCAN, EMIT, TERM; busy SHALL be high in every state except IDLE.
REQ-009 IDLE->SCAN SHALL occur on query acceptance, latching q_node and setting the scan index to 0.
REQ-010 In SCAN the block SHALL examine one entry per cycle; on src == latched node it SHALL go to EMIT with out_node = dst, out_hit = 1, out_last = 0; otherwise it SHALL advance the index.
REQ-011 In EMIT, out_valid SHALL be high with out_node stable until out_ready; on the handshake the FSM SHALL return to SCAN at index+1.
REQ-012 When the index reaches edge_count, the FSM SHALL go to TERM, presenting out_valid = 1, out_hit = 0, out_last = 1, out_node = 0 until out_ready, then return to IDLE.
REQ-013 Matches SHALL be emitted in insertion order, duplicates included.
REQ-014 With out_ready held high, entry i of a query accepted in cycle n SHALL be examined in cycle n+1+i+(hits before i).
REQ-015 An empty table or a node with no fanout SHALL yield exactly one terminator beat.
REQ-016 The edge count captured at query acceptance SHALL bound the scan.

Reset
REQ-017 rst SHALL asynchronously force IDLE, edge_count = 0, out_valid = 0, out_hit = 0, out_last = 0, out_node = 0, busy = 0, wr_ready = 1, q_ready = 1.
REQ-018 Reset mid-query SHALL abort the response without emitting a terminator.

Structure
REQ-019 Package netlist_graph_pkg SHALL hold NODE_W default, node_t, edge_t (src, dst) and the FSM state enum.
REQ-020 Storage and edge_count SHALL be in sub-module fanout_edge_table (write port, clear, one combinational read port).

Verification
REQ-021 Load (1,3),(2,3),(1,4),(3,5); query 1 -> beats 3/hit, 4/hit, 0/last/no-hit.
REQ-022 Empty table, query 7 -> a single terminator in cycle n+1; edge_count 0.
REQ-023 Load 16 edges -> wr_ready = 0, 17th write ignored, edge_count = 16; clr -> 0.
REQ-024 Query with out_ready low for 5 cycles on first hit -> out_node held constant, no entries skipped.
REQ-025 Write and clr in the same cycle -> edge_count 0; write during busy -> wr_ready = 0 and no store.
REQ-026 rst asserted during EMIT -> outputs zero immediately, q_ready = 1 after release, table empty.
